// File: rtl/id_operand_stage_if.sv
// id_operand_stage_if: fetch/execute handshakes, register-file and hazard-detector signals of the decode operand stage.
interface id_operand_stage_if;
  logic        flush;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        ds_allowin;
  logic        es_allowin;
  logic        ds_to_es_valid;
  logic [31:0] ds_pc;
  logic [31:0] ds_inst;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        pause;
  logic        addr1_occur;
  logic        addr2_occur;
  logic [31:0] addr1_forward;
  logic [31:0] addr2_forward;
  logic [31:0] ds_src1;
  logic [31:0] ds_src2;
  modport master (
    input  flush, fs_to_ds_valid, fs_pc, fs_inst, es_allowin, rf_rdata1, rf_rdata2,
           pause, addr1_occur, addr2_occur, addr1_forward, addr2_forward,
    output ds_allowin, ds_to_es_valid, ds_pc, ds_inst, rf_raddr1, rf_raddr2, ds_src1, ds_src2
  );
  modport slave (
    output flush, fs_to_ds_valid, fs_pc, fs_inst, es_allowin, rf_rdata1, rf_rdata2,
           pause, addr1_occur, addr2_occur, addr1_forward, addr2_forward,
    input  ds_allowin, ds_to_es_valid, ds_pc, ds_inst, rf_raddr1, rf_raddr2, ds_src1, ds_src2
  );
endinterface

// File: rtl/id_operand_stage.sv
// id_operand_stage: decode payload latch, operand resolution with forwarding, and operand hold while execute stalls.
// Defining ID_STALL_CNT_EN adds the stall_cnt port counting hazard stall cycles.
module id_operand_stage (
  input logic clk,
  input logic resetn,
  id_operand_stage_if.master bus
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  logic        ds_valid;
  logic        hold_valid;
  logic        ds_ready_go;
  logic        hold_set;
  logic        hold_clr;
  logic        use_rd;
  logic [5:0]  op;
  logic [31:0] ds_pc;
  logic [31:0] ds_inst;
  logic [31:0] hold1;
  logic [31:0] hold2;
  logic [31:0] live1;
  logic [31:0] live2;
  assign op             = ds_inst[31:26];
  assign use_rd         = (op >= 6'h16 && op <= 6'h1b) || ds_inst[31:24] == 8'h29;
  assign bus.ds_pc      = ds_pc;
  assign bus.ds_inst    = ds_inst;
  assign bus.rf_raddr1  = ds_inst[9:5];
  assign bus.rf_raddr2  = use_rd ? ds_inst[4:0] : ds_inst[14:10];
  assign live1          = bus.rf_raddr1 == 5'd0 ? 32'd0 : bus.addr1_occur ? bus.addr1_forward : bus.rf_rdata1;
  assign live2          = bus.rf_raddr2 == 5'd0 ? 32'd0 : bus.addr2_occur ? bus.addr2_forward : bus.rf_rdata2;
  assign bus.ds_src1    = hold_valid ? hold1 : live1;
  assign bus.ds_src2    = hold_valid ? hold2 : live2;
  // Once operands are frozen the hazard result no longer matters.
  assign ds_ready_go    = hold_valid | ~bus.pause;
  assign bus.ds_allowin = ~ds_valid | (ds_ready_go & bus.es_allowin);
  assign bus.ds_to_es_valid = ds_valid & ds_ready_go & ~bus.flush;
  assign hold_set       = ds_valid & ~bus.pause & ~bus.es_allowin & ~hold_valid & ~bus.flush;
  assign hold_clr       = bus.flush | (bus.es_allowin & ds_valid);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ds_valid   <= 1'b0;
      hold_valid <= 1'b0;
      ds_pc      <= 32'd0;
      ds_inst    <= 32'd0;
      hold1      <= 32'd0;
      hold2      <= 32'd0;
    end else begin
      if (bus.fs_to_ds_valid && bus.ds_allowin) begin
        ds_pc   <= bus.fs_pc;
        ds_inst <= bus.fs_inst;
      end
      ds_valid   <= bus.flush ? 1'b0 : bus.ds_allowin ? bus.fs_to_ds_valid : ds_valid;
      hold_valid <= hold_clr ? 1'b0 : hold_set ? 1'b1 : hold_valid;
      if (hold_set) begin
        hold1 <= live1;
        hold2 <= live2;
      end
    end
  end
`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stall_cnt <= 32'd0;
    else if (ds_valid && !ds_ready_go && !bus.flush) stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: random stimulus against a queue-based reference model, a decode/operand vector table, and directed stall/flush/reset sequences.
module tb_id_operand_stage;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  id_operand_stage_if bus();
`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] base;
`endif
  id_operand_stage dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic [31:0] inst, rd1, rd2, f1, f2;
    logic        o1, o2;
    logic [4:0]  ra1, ra2;
    logic [31:0] s1, s2;
  } vec_t;
  vec_t vt[8];
  bit          m_valid;
  logic [31:0] m_pc, m_inst, m_cnt, l1, l2, e1, e2;
  logic [63:0] frozen[$];
  bit          ready, allow;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [4:0] ref_ra2(input logic [31:0] i);
    int op;
    op = int'(i[31:26]);
    return ((op >= 22 && op <= 27) || i[31:24] == 8'h29) ? i[4:0] : i[14:10];
  endfunction
  function automatic logic [31:0] ref_opnd(input logic [4:0] ra, input logic occ, input logic [31:0] fw, input logic [31:0] rd);
    return ra == 5'd0 ? 32'd0 : occ ? fw : rd;
  endfunction
  task automatic idle();
    bus.flush = 0; bus.fs_to_ds_valid = 0; bus.fs_pc = 0; bus.fs_inst = 0; bus.es_allowin = 1;
    bus.rf_rdata1 = 0; bus.rf_rdata2 = 0; bus.pause = 0; bus.addr1_occur = 0; bus.addr2_occur = 0;
    bus.addr1_forward = 0; bus.addr2_forward = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
    tick();
    bus.fs_to_ds_valid = 1; bus.fs_pc = pc; bus.fs_inst = inst;
    tick();
    bus.fs_to_ds_valid = 0;
  endtask
  initial begin
    vt[0] = '{32'h00100823, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd5, 32'd7};
    vt[1] = '{32'h00100823, 32'h12345678, 32'd7, 32'hDEAD0000, 32'd0, 1'b1, 1'b0, 5'd1, 5'd2, 32'hDEAD0000, 32'd7};
    vt[2] = '{32'h29800004, 32'h11111111, 32'h22222222, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd4, 32'd0, 32'h22222222};
    vt[3] = '{32'h580024A6, 32'h0000AAAA, 32'h0000BBBB, 32'd0, 32'hCAFEF00D, 1'b0, 1'b1, 5'd5, 5'd6, 32'h0000AAAA, 32'hCAFEF00D};
    vt[4] = '{32'h6C0028E8, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 5'd7, 5'd8, 32'd1, 32'd2};
    vt[5] = '{32'h70003061, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd12, 32'd3, 32'd4};
    vt[6] = '{32'h54003061, 32'd3, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 5'd3, 5'd12, 32'd3, 32'd4};
    vt[7] = '{32'h28800004, 32'd9, 32'd9, 32'd0, 32'h77777777, 1'b0, 1'b1, 5'd0, 5'd0, 32'd0, 32'd0};
    idle();
    #2;
    chk("rst_tv", 32'(bus.ds_to_es_valid), 32'd0);
    chk("rst_allowin", 32'(bus.ds_allowin), 32'd1);
    chk("rst_pc", bus.ds_pc, 32'd0);
    chk("rst_inst", bus.ds_inst, 32'd0);
`ifdef ID_STALL_CNT_EN
    chk("rst_cnt", stall_cnt, 32'd0);
`endif
    #10 resetn = 1;
    m_valid = 0; m_pc = 0; m_inst = 0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      case ($urandom_range(0, 3))
        0: bus.fs_inst = $urandom;
        1: bus.fs_inst = {6'($urandom_range(21, 28)), 26'($urandom)};
        2: bus.fs_inst = {8'($urandom_range(40, 41)), 24'($urandom)};
        default: bus.fs_inst = $urandom & 32'hFFFFFC1F;
      endcase
      bus.fs_to_ds_valid = 1'($urandom_range(0, 1));
      bus.fs_pc = $urandom;
      bus.es_allowin = $urandom_range(0, 3) != 0;
      bus.pause = $urandom_range(0, 3) == 0;
      bus.flush = $urandom_range(0, 15) == 0;
      bus.rf_rdata1 = $urandom; bus.rf_rdata2 = $urandom;
      bus.addr1_occur = 1'($urandom_range(0, 1)); bus.addr2_occur = 1'($urandom_range(0, 1));
      bus.addr1_forward = $urandom; bus.addr2_forward = $urandom;
      #1;
      ready = frozen.size() != 0 || !bus.pause;
      allow = !m_valid || (ready && bus.es_allowin);
      l1 = ref_opnd(m_inst[9:5], bus.addr1_occur, bus.addr1_forward, bus.rf_rdata1);
      l2 = ref_opnd(ref_ra2(m_inst), bus.addr2_occur, bus.addr2_forward, bus.rf_rdata2);
      e1 = frozen.size() != 0 ? frozen[0][63:32] : l1;
      e2 = frozen.size() != 0 ? frozen[0][31:0] : l2;
      chk($sformatf("rnd%0d_allowin", c), 32'(bus.ds_allowin), 32'(allow));
      chk($sformatf("rnd%0d_tv", c), 32'(bus.ds_to_es_valid), 32'(m_valid && ready && !bus.flush));
      chk($sformatf("rnd%0d_pc", c), bus.ds_pc, m_pc);
      chk($sformatf("rnd%0d_ra1", c), 32'(bus.rf_raddr1), 32'(m_inst[9:5]));
      chk($sformatf("rnd%0d_ra2", c), 32'(bus.rf_raddr2), 32'(ref_ra2(m_inst)));
      chk($sformatf("rnd%0d_src1", c), bus.ds_src1, e1);
      chk($sformatf("rnd%0d_src2", c), bus.ds_src2, e2);
`ifdef ID_STALL_CNT_EN
      chk($sformatf("rnd%0d_cnt", c), stall_cnt, m_cnt);
`endif
      if (m_valid && !ready && !bus.flush) m_cnt++;
      if (bus.flush || (bus.es_allowin && m_valid)) frozen.delete();
      else if (m_valid && !bus.pause && frozen.size() == 0) frozen.push_back({l1, l2});
      if (bus.fs_to_ds_valid && allow) begin
        m_pc = bus.fs_pc;
        m_inst = bus.fs_inst;
      end
      m_valid = bus.flush ? 1'b0 : allow ? bus.fs_to_ds_valid : m_valid;
    end
    tick();
    idle();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    for (int i = 0; i < 8; i++) begin
      fetch(32'h1C000000 + 32'(i * 4), vt[i].inst);
      bus.rf_rdata1 = vt[i].rd1; bus.rf_rdata2 = vt[i].rd2;
      bus.addr1_occur = vt[i].o1; bus.addr2_occur = vt[i].o2;
      bus.addr1_forward = vt[i].f1; bus.addr2_forward = vt[i].f2;
      #1;
      chk($sformatf("vec%0d_tv", i), 32'(bus.ds_to_es_valid), 32'd1);
      chk($sformatf("vec%0d_pc", i), bus.ds_pc, 32'h1C000000 + 32'(i * 4));
      chk($sformatf("vec%0d_ra1", i), 32'(bus.rf_raddr1), 32'(vt[i].ra1));
      chk($sformatf("vec%0d_ra2", i), 32'(bus.rf_raddr2), 32'(vt[i].ra2));
      chk($sformatf("vec%0d_src1", i), bus.ds_src1, vt[i].s1);
      chk($sformatf("vec%0d_src2", i), bus.ds_src2, vt[i].s2);
    end
    tick();
    idle();
    bus.rf_rdata1 = 5; bus.rf_rdata2 = 7;
    fetch(32'h1C000100, 32'h00100823);
    bus.pause = 1;
    #1;
`ifdef ID_STALL_CNT_EN
    base = stall_cnt;
`endif
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("pause%0d_tv", k), 32'(bus.ds_to_es_valid), 32'd0);
      chk($sformatf("pause%0d_allowin", k), 32'(bus.ds_allowin), 32'd0);
      tick();
    end
    bus.pause = 0;
    #1;
    chk("pause_go_tv", 32'(bus.ds_to_es_valid), 32'd1);
    chk("pause_go_src1", bus.ds_src1, 32'd5);
`ifdef ID_STALL_CNT_EN
    chk("pause_cnt", stall_cnt, base + 32'd3);
`endif
    tick();
    chk("pause_after_tv", 32'(bus.ds_to_es_valid), 32'd0);
    bus.es_allowin = 0; bus.addr2_occur = 1; bus.addr2_forward = 32'h11;
    fetch(32'h1C000200, 32'h00100823);
    #1;
    chk("hold_c1_src2", bus.ds_src2, 32'h11);
    chk("hold_c1_tv", 32'(bus.ds_to_es_valid), 32'd1);
    chk("hold_c1_allowin", 32'(bus.ds_allowin), 32'd0);
    tick();
    bus.addr2_forward = 32'h22;
    #1;
    chk("hold_c2_src2", bus.ds_src2, 32'h11);
    tick();
    bus.es_allowin = 1;
    #1;
    chk("hold_c3_src2", bus.ds_src2, 32'h11);
    chk("hold_c3_tv", 32'(bus.ds_to_es_valid), 32'd1);
    tick();
    chk("hold_after_tv", 32'(bus.ds_to_es_valid), 32'd0);
    chk("hold_after_src2", bus.ds_src2, 32'h22);
    idle();
    fetch(32'h1C000300, 32'h29800004);
    bus.es_allowin = 0;
    #1;
    chk("st_ra2", 32'(bus.rf_raddr2), 32'd4);
    chk("st_tv", 32'(bus.ds_to_es_valid), 32'd1);
    bus.flush = 1; bus.fs_to_ds_valid = 1; bus.fs_inst = 32'h00100823;
    #1;
    chk("flush_now_tv", 32'(bus.ds_to_es_valid), 32'd0);
    tick();
    bus.flush = 0; bus.fs_to_ds_valid = 0; bus.es_allowin = 1;
    #1;
    chk("flush_next_tv", 32'(bus.ds_to_es_valid), 32'd0);
    chk("flush_next_allowin", 32'(bus.ds_allowin), 32'd1);
    chk("flush_next_inst", bus.ds_inst, 32'h29800004);
    bus.flush = 1; bus.fs_to_ds_valid = 1;
    tick();
    bus.flush = 0; bus.fs_to_ds_valid = 0;
    #1;
    chk("flush_empty_tv", 32'(bus.ds_to_es_valid), 32'd0);
    bus.rf_rdata1 = 32'h55; bus.rf_rdata2 = 32'h66;
    fetch(32'h1C000400, 32'h00100823);
    bus.pause = 1;
    #1;
    chk("rstmid_stall_tv", 32'(bus.ds_to_es_valid), 32'd0);
    #1 resetn = 0;
    #1;
    chk("rstmid_tv", 32'(bus.ds_to_es_valid), 32'd0);
    chk("rstmid_allowin", 32'(bus.ds_allowin), 32'd1);
    chk("rstmid_pc", bus.ds_pc, 32'd0);
    chk("rstmid_inst", bus.ds_inst, 32'd0);
    chk("rstmid_src1", bus.ds_src1, 32'd0);
    chk("rstmid_src2", bus.ds_src2, 32'd0);
`ifdef ID_STALL_CNT_EN
    chk("rstmid_cnt", stall_cnt, 32'd0);
`endif
    bus.pause = 0;
    tick();
    #2 resetn = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rstrel%0d_tv", k), 32'(bus.ds_to_es_valid), 32'd0);
      chk($sformatf("rstrel%0d_allowin", k), 32'(bus.ds_allowin), 32'd1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
